board_mem_arbiter: RTL
======================

Name: board_mem_arbiter

Overview:
Arbitrates the single 64-entry x 4-bit board memory (one 4-bit piece code per square) between four requesters: control, validator, datapath and view. It replaces hard-wired state-decoded memory selection with a request/grant handshake. It uses round-robin fairness, per-owner bus locking and a hold timeout. It drives the synchronous RAM port and routes read data back to the owner with a valid strobe.

Parameters:
MAX_HOLD, 64, cycles an owner may keep the grant while another requester waits before a forced release; 0 disables the timeout.
CNT_W, 7, width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
clk  input  1  system clock, all state on rising edge.
resetn  input  1  reset; asynchronous, active-low.
req  input  4  bus request per requester: bit0 control, bit1 validator, bit2 datapath, bit3 view.
acc  input  4  access strobe per requester; effective only for the current owner.
wren  input  4  per-requester write enable; qualified by acc.
addr  input  24  packed addresses; requester i uses [6i+5:6i], address = y*8 + x.
wdata  input  16  packed write data; requester i uses [4i+3:4i].
grant  output  4  one-hot grant, registered; all-zero when no owner.
owner  output  2  index of the granted requester (00 control, 01 validator, 10 datapath, 11 view); holds the last owner when idle.
mem_address  output  6  RAM address.
mem_data  output  4  RAM write data.
mem_wren  output  1  RAM write enable.
mem_q  input  4  RAM read data; valid 1 cycle after the address is presented.
rdata  output  4  read data returned to the owner.
rvalid  output  4  one-hot read-data strobe, 1 cycle after the read access.
hold_timeout  output  1  1-cycle pulse when a forced release occurs.

Behaviour:
- Reset (resetn=0, asynchronous):
  - state=S_IDLE; grant=0; owner=00; rvalid=0; rdata=0; hold_timeout=0; hold counter=0.
  - Round-robin pointer=0, so control has the highest priority first.
  - mem_wren=0 immediately. An in-flight write is abandoned.
- FSM states: S_IDLE, S_OWNED, S_HANDOVER.
- S_IDLE:
  - If req!=0, select the first set bit scanning from the pointer upward with wrap (3 -> 0).
  - At the next edge: grant=one-hot(sel), owner=sel, counter=0, go to S_OWNED.
  - Grant latency is 1 cycle from req.
- S_OWNED:
  - mem_address = addr[owner] and mem_data = wdata[owner], combinational mux.
  - mem_wren = acc[owner] & wren[owner] & req[owner].
  - Read: acc[owner]=1 and wren[owner]=0 at cycle N -> rvalid[owner]=1 and rdata=mem_q at cycle N+1, registered tag.
  - acc or wren from non-owners is ignored and produces no rvalid.
  - Counter increments each cycle and saturates at MAX_HOLD.
- Release:
  - If req[owner]=0, go to S_HANDOVER at the next edge.
  - grant clears on that edge; pointer = owner+1 (mod 4).
  - acc in a cycle with req[owner]=0 is ignored.
- Timeout:
  - If MAX_HOLD!=0, counter==MAX_HOLD and (req & ~grant)!=0, go to S_HANDOVER.
  - hold_timeout=1 for exactly that transition cycle; pointer = owner+1.
  - The evicted requester must re-win arbitration.
  - If no other request is pending, the counter stays saturated and ownership continues.
- S_HANDOVER:
  - Exactly 1 cycle; grant=0, mem_wren=0.
  - A read issued in the last owned cycle still delivers rvalid to the old owner in this cycle.
  - Then arbitrate as in S_IDLE: with pending req, go directly to S_OWNED at the next edge; otherwise S_IDLE.
- Simultaneous events: release and timeout in the same cycle count as a release (no hold_timeout pulse).
- Reset mid-read: any pending rvalid is dropped.
- rvalid is never asserted for more than one requester.
- Address width is fixed at 6 bits (no wrap handling needed). Data passes through unmodified.

Test Plan:
- Reset: hold resetn=0 with req=4'b1111 -> grant=0, owner=00, mem_wren=0. Release reset -> grant=0001 one cycle later.
- Single write then read: datapath req, acc+wren, addr=6'd12, wdata=4'd6 -> mem_wren=1 with mem_address=12. Next read of 12 -> rvalid=0100 and rdata=6 one cycle after acc.
- Round-robin: req=1111 held, each owner releases after 2 cycles -> grant order 0001, 0010, 0100, 1000, 0001, with one zero-grant handover cycle between owners.
- Ignored non-owner: validator owns while view pulses acc+wren at addr 3 -> no write to 3, rvalid stays 0 for view.
- Timeout: MAX_HOLD=4, view holds req while control requests -> hold_timeout pulses once after 4 owned cycles, handover, grant=0001. With no competitor, view keeps its grant indefinitely.
- Async reset mid-read: assert resetn=0 the cycle after a read acc -> rvalid=0 immediately, state S_IDLE.

Source files
------------

// File: rtl/board_mem_arbiter.sv
// Board memory arbiter: round-robin request/grant access to the 64x4 board RAM
// with per-owner bus locking, a hold timeout and tagged read-data return.
module board_mem_arbiter #(
  parameter int MAX_HOLD = 64,
  parameter int CNT_W    = 7
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [3:0]  req,
  input  logic [3:0]  acc,
  input  logic [3:0]  wren,
  input  logic [23:0] addr,
  input  logic [15:0] wdata,
  output logic [3:0]  grant,
  output logic [1:0]  owner,
  output logic [5:0]  mem_address,
  output logic [3:0]  mem_data,
  output logic        mem_wren,
  input  logic [3:0]  mem_q,
  output logic [3:0]  rdata,
  output logic [3:0]  rvalid,
  output logic        hold_timeout
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'b00,
    S_OWNED    = 2'b01,
    S_HANDOVER = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);

  state_t           state_r, state_s;
  logic [3:0]       grant_r, grant_s;
  logic [1:0]       owner_r, owner_s;
  logic [1:0]       ptr_r, ptr_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [3:0]       rvalid_r, rvalid_s;
  logic             timeout_r, timeout_s;
  logic             own_req_s, own_acc_s, own_wren_s;
  logic             hold_max_s, others_s;
  logic [2:0]       pick_s;

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  // {found, index}: first set request scanning upward from p with wrap
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      idx = p + 2'(i);
      if (r[idx]) begin
        res = {1'b1, idx};
      end
    end
    return res;
  endfunction

  // Owner-side request decode and RAM address/data mux
  always_comb begin
    own_req_s  = req[owner_r];
    own_acc_s  = acc[owner_r];
    own_wren_s = wren[owner_r];
    hold_max_s = (MAX_HOLD != 0) && (cnt_r == HOLD_MAX);
    others_s   = |(req & ~grant_r);
    pick_s     = rr_pick(req, ptr_r);
    case (owner_r)
      2'd0:    begin mem_address = addr[5:0];   mem_data = wdata[3:0];   end
      2'd1:    begin mem_address = addr[11:6];  mem_data = wdata[7:4];   end
      2'd2:    begin mem_address = addr[17:12]; mem_data = wdata[11:8];  end
      2'd3:    begin mem_address = addr[23:18]; mem_data = wdata[15:12]; end
      default: begin mem_address = 6'd0;        mem_data = 4'd0;         end
    endcase
  end

  // Arbitration FSM next state, write enable and read tagging
  always_comb begin
    state_s   = state_r;
    grant_s   = grant_r;
    owner_s   = owner_r;
    ptr_s     = ptr_r;
    cnt_s     = cnt_r;
    rvalid_s  = 4'b0000;
    timeout_s = 1'b0;
    mem_wren  = 1'b0;
    case (state_r)
      S_IDLE, S_HANDOVER: begin
        grant_s = 4'b0000;
        if (pick_s[2]) begin
          state_s = S_OWNED;
          grant_s = onehot(pick_s[1:0]);
          owner_s = pick_s[1:0];
          cnt_s   = CNT_W'(0);
        end else begin
          state_s = S_IDLE;
        end
      end
      S_OWNED: begin
        mem_wren = own_req_s & own_acc_s & own_wren_s;
        // a read in the final owned cycle is still returned during handover
        if (own_req_s && own_acc_s && !own_wren_s) begin
          rvalid_s = onehot(owner_r);
        end else begin
          rvalid_s = 4'b0000;
        end
        if (!own_req_s) begin
          state_s = S_HANDOVER;
          grant_s = 4'b0000;
          ptr_s   = owner_r + 2'd1;
        end else if (hold_max_s && others_s) begin
          state_s   = S_HANDOVER;
          grant_s   = 4'b0000;
          ptr_s     = owner_r + 2'd1;
          timeout_s = 1'b1;
        end else if (cnt_r != HOLD_MAX) begin
          cnt_s = cnt_r + CNT_W'(1);
        end else begin
          cnt_s = cnt_r;
        end
      end
      default: begin
        state_s = S_IDLE;
        grant_s = 4'b0000;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r   <= S_IDLE;
      grant_r   <= 4'b0000;
      owner_r   <= 2'b00;
      ptr_r     <= 2'b00;
      cnt_r     <= CNT_W'(0);
      rvalid_r  <= 4'b0000;
      timeout_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      grant_r   <= grant_s;
      owner_r   <= owner_s;
      ptr_r     <= ptr_s;
      cnt_r     <= cnt_s;
      rvalid_r  <= rvalid_s;
      timeout_r <= timeout_s;
    end
  end

  assign grant        = grant_r;
  assign owner        = owner_r;
  assign rvalid       = rvalid_r;
  assign hold_timeout = timeout_r;
  assign rdata        = (rvalid_r != 4'b0000) ? mem_q : 4'b0000;

endmodule
